// File: rtl/pc_branch_unit_pkg.sv
// Shared types and branch-target constants
// for the PC / branch-resolution stage.
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    BR_ALW = 2'd0,
    BR_EQ  = 2'd1,
    BR_GT  = 2'd2,
    BR_LT  = 2'd3
  } br_cond_e;

  localparam int unsigned BR_TGT_0 = 12;
  localparam int unsigned BR_TGT_1 = 7;
  localparam int unsigned BR_TGT_2 = 20;
  localparam int unsigned BR_TGT_3 = 40;
  localparam int unsigned BR_TGT_4 = 100;
  localparam int unsigned BR_TGT_5 = 3;
  localparam int unsigned BR_TGT_6 = 511;
  localparam int unsigned BR_TGT_7 = 1023;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode/flag inputs and PC/status outputs
// of the PC / branch-resolution stage.
interface pc_branch_unit_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned LUT_W = 5
);
  logic             START;
  logic             HALT_REQ;
  logic             FLAG_WE;
  logic             ZERO;
  logic             GREATER;
  logic             BRANCH;
  logic [1:0]       BR_COND;
  logic [LUT_W-1:0] BR_IDX;
  logic [PC_W-1:0]  PC;
  logic             FETCH_VALID;
  logic             DONE;
  logic             FLAG_Z;
  logic             FLAG_G;

  modport master (
    output START, HALT_REQ, FLAG_WE,
    output ZERO, GREATER, BRANCH,
    output BR_COND, BR_IDX,
    input  PC, FETCH_VALID, DONE,
    input  FLAG_Z, FLAG_G
  );

  modport slave (
    input  START, HALT_REQ, FLAG_WE,
    input  ZERO, GREATER, BRANCH,
    input  BR_COND, BR_IDX,
    output PC, FETCH_VALID, DONE,
    output FLAG_Z, FLAG_G
  );
endinterface

// File: rtl/pc_branch_unit_lut.sv
// Combinational branch-target table.
// Unlisted indices fall back to START_ADDR.
module branch_lut
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_W      = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  always_comb begin
    target = PC_W'(START_ADDR);
    case (idx)
      LUT_W'(0): target = PC_W'(BR_TGT_0);
      LUT_W'(1): target = PC_W'(BR_TGT_1);
      LUT_W'(2): target = PC_W'(BR_TGT_2);
      LUT_W'(3): target = PC_W'(BR_TGT_3);
      LUT_W'(4): target = PC_W'(BR_TGT_4);
      LUT_W'(5): target = PC_W'(BR_TGT_5);
      LUT_W'(6): target = PC_W'(BR_TGT_6);
      LUT_W'(7): target = PC_W'(BR_TGT_7);
      default:   target = PC_W'(START_ADDR);
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, flag register and run/halt
// sequencing with one-cycle table branches.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_W      = 5,
  parameter int unsigned START_ADDR = 0
) (
  input logic              CLK,
  input logic              RESET_N,
  pc_branch_unit_if.slave  bus
);

  localparam logic [PC_W-1:0] START_PC =
    PC_W'(START_ADDR);

  pc_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] br_tgt;
  logic            flag_z_q;
  logic            flag_g_q;
  logic            cond_ok;

  branch_lut #(
    .PC_W       (PC_W),
    .LUT_W      (LUT_W),
    .START_ADDR (START_ADDR)
  ) u_lut (
    .idx    (bus.BR_IDX),
    .target (br_tgt)
  );

  // Branch sees the registered flags only;
  // a same-cycle compare is not bypassed.
  always_comb begin
    cond_ok = 1'b0;
    unique case (br_cond_e'(bus.BR_COND))
      BR_ALW: cond_ok = 1'b1;
      BR_EQ:  cond_ok = flag_z_q;
      BR_GT:  cond_ok = flag_g_q;
      BR_LT:  cond_ok = !flag_z_q && !flag_g_q;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      flag_z_q <= 1'b0;
      flag_g_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.START) state_q <= RUN;
        end
        RUN: begin
          if (bus.FLAG_WE) begin
            flag_z_q <= bus.ZERO;
            flag_g_q <= bus.GREATER;
          end
          if (bus.HALT_REQ)
            state_q <= HALT;
          else if (bus.BRANCH && cond_ok)
            pc_q <= br_tgt;
          else
            pc_q <= pc_q + PC_W'(1);
        end
        HALT: begin
          if (bus.START) begin
            state_q  <= RUN;
            pc_q     <= START_PC;
            flag_z_q <= 1'b0;
            flag_g_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.FETCH_VALID = (state_q == RUN);
  assign bus.DONE        = (state_q == HALT);
  assign bus.FLAG_Z      = flag_z_q;
  assign bus.FLAG_G      = flag_g_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed plus random bench for pc_branch_unit
// (PC_W=10 and PC_W=4 instances share stimulus).
module tb_pc_branch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, halt_req, flag_we;
  logic       zero, greater, branch;
  logic [1:0] br_cond;
  logic [4:0] br_idx;

  pc_branch_unit_if #(.PC_W(10), .LUT_W(5)) b10 ();
  pc_branch_unit_if #(.PC_W(4),  .LUT_W(5)) b4 ();

  assign b10.START    = start;
  assign b10.HALT_REQ = halt_req;
  assign b10.FLAG_WE  = flag_we;
  assign b10.ZERO     = zero;
  assign b10.GREATER  = greater;
  assign b10.BRANCH   = branch;
  assign b10.BR_COND  = br_cond;
  assign b10.BR_IDX   = br_idx;
  assign b4.START     = start;
  assign b4.HALT_REQ  = halt_req;
  assign b4.FLAG_WE   = flag_we;
  assign b4.ZERO      = zero;
  assign b4.GREATER   = greater;
  assign b4.BRANCH    = branch;
  assign b4.BR_COND   = br_cond;
  assign b4.BR_IDX    = br_idx;

  pc_branch_unit #(
    .PC_W(10), .LUT_W(5), .START_ADDR(0)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .bus(b10)
  );

  pc_branch_unit #(
    .PC_W(4), .LUT_W(5), .START_ADDR(0)
  ) dut4 (
    .CLK(clk), .RESET_N(rst_n), .bus(b4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: 0 idle, 1 run, 2 halt
  int m_state = 0;
  int m_pc = 0;
  int m_pc4 = 0;
  int m_z = 0;
  int m_g = 0;

  function automatic int lut(int idx);
    case (idx)
      0: return 12;
      1: return 7;
      2: return 20;
      3: return 40;
      4: return 100;
      5: return 3;
      6: return 511;
      7: return 1023;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    bit taken;
    if (!rst_n) begin
      m_state = 0; m_pc = 0; m_pc4 = 0;
      m_z = 0; m_g = 0;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      taken = branch && (
        (br_cond == 2'd0) ||
        (br_cond == 2'd1 && m_z == 1) ||
        (br_cond == 2'd2 && m_g == 1) ||
        (br_cond == 2'd3 && m_z == 0 && m_g == 0));
      if (flag_we) begin
        m_z = int'(zero);
        m_g = int'(greater);
      end
      if (halt_req) m_state = 2;
      else if (taken) begin
        m_pc  = lut(int'(br_idx));
        m_pc4 = lut(int'(br_idx)) % 16;
      end else begin
        m_pc  = (m_pc + 1) % 1024;
        m_pc4 = (m_pc4 + 1) % 16;
      end
    end else begin
      if (start) begin
        m_state = 1; m_pc = 0; m_pc4 = 0;
        m_z = 0; m_g = 0;
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".pc"}, int'(b10.PC), m_pc);
    chk({tag, ".pc4"}, int'(b4.PC), m_pc4);
    chk({tag, ".fv"}, int'(b10.FETCH_VALID),
        int'(m_state == 1));
    chk({tag, ".done"}, int'(b10.DONE),
        int'(m_state == 2));
    chk({tag, ".z"}, int'(b10.FLAG_Z), m_z);
    chk({tag, ".g"}, int'(b10.FLAG_G), m_g);
    chk({tag, ".fv4"}, int'(b4.FETCH_VALID),
        int'(m_state == 1));
  endtask

  task automatic quiet();
    start = 0; halt_req = 0; flag_we = 0;
    zero = 0; greater = 0; branch = 0;
    br_cond = 2'd0; br_idx = 5'd0;
  endtask

  // Apply current inputs across one edge,
  // then check at the following falling edge.
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    quiet();
    rst_n = 0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    chk("rst.pc", int'(b10.PC), 0);
    chk("rst.fv", int'(b10.FETCH_VALID), 0);
    rst_n = 1;

    // Reset mid-run with flags set
    start = 1;
    step("mr.start");
    quiet();
    chk("mr.fv", int'(b10.FETCH_VALID), 1);
    flag_we = 1; zero = 1; greater = 1;
    step("mr.cmp");
    quiet();
    for (int i = 0; i < 20 && m_pc != 7; i++)
      step("mr.run");
    chk("mr.pc7", int'(b10.PC), 7);
    rst_n = 0;
    step("mr.rst");
    rst_n = 1;
    chk("mr.rpc", int'(b10.PC), 0);
    chk("mr.rz", int'(b10.FLAG_Z), 0);
    chk("mr.rg", int'(b10.FLAG_G), 0);
    chk("mr.rfv", int'(b10.FETCH_VALID), 0);
    chk("mr.rdone", int'(b10.DONE), 0);

    // Sequential fetch with 4-bit wrap
    start = 1;
    step("wr.start");
    quiet();
    for (int i = 1; i <= 17; i++) begin
      step("wr.seq");
      chk("wr.pc4", int'(b4.PC), i % 16);
      chk("wr.fv4", int'(b4.FETCH_VALID), 1);
    end

    // Compare then branch EQ (lut[3] = 40)
    flag_we = 1; zero = 1;
    step("eq.cmp");
    quiet();
    branch = 1; br_cond = 2'b01; br_idx = 5'd3;
    step("eq.br");
    quiet();
    chk("eq.taken", int'(b10.PC), 40);
    flag_we = 1; zero = 0;
    step("eq.cmp0");
    quiet();
    branch = 1; br_cond = 2'b01; br_idx = 5'd3;
    step("eq.br0");
    quiet();
    chk("eq.nottaken", int'(b10.PC), 42);

    // Same-cycle compare and branch
    flag_we = 1; zero = 1;
    branch = 1; br_cond = 2'b01; br_idx = 5'd3;
    step("sc.br");
    quiet();
    chk("sc.pc", int'(b10.PC), 43);
    chk("sc.z", int'(b10.FLAG_Z), 1);

    // LT condition
    flag_we = 1;
    step("lt.cmp");
    quiet();
    branch = 1; br_cond = 2'b11; br_idx = 5'd1;
    step("lt.br");
    quiet();
    chk("lt.taken", int'(b10.PC), 7);
    flag_we = 1; greater = 1;
    step("lt.cmpg");
    quiet();
    branch = 1; br_cond = 2'b11; br_idx = 5'd1;
    step("lt.brg");
    quiet();
    chk("lt.nottaken", int'(b10.PC), 9);

    // Halt priority at PC 12, then restart
    branch = 1; br_cond = 2'b00; br_idx = 5'd0;
    step("h.jmp");
    quiet();
    chk("h.pc12", int'(b10.PC), 12);
    halt_req = 1; branch = 1;
    br_cond = 2'b00; br_idx = 5'd2;
    step("h.halt");
    quiet();
    chk("h.done", int'(b10.DONE), 1);
    chk("h.pc", int'(b10.PC), 12);
    for (int i = 0; i < 6; i++) begin
      flag_we = 1; zero = 1; greater = 0;
      branch = 1;
      step("h.hold");
      chk("h.holdpc", int'(b10.PC), 12);
      chk("h.holdz", int'(b10.FLAG_Z), 0);
    end
    quiet();
    start = 1;
    step("h.restart");
    quiet();
    chk("h.rpc", int'(b10.PC), 0);
    chk("h.rdone", int'(b10.DONE), 0);
    chk("h.rfv", int'(b10.FETCH_VALID), 1);
    chk("h.rg", int'(b10.FLAG_G), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      start    = ($urandom_range(0, 14) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      flag_we  = 1'($urandom_range(0, 1));
      zero     = 1'($urandom_range(0, 1));
      greater  = 1'($urandom_range(0, 1));
      branch   = 1'($urandom_range(0, 1));
      br_cond  = 2'($urandom_range(0, 3));
      br_idx   = 5'($urandom_range(0, 31));
      step("rnd");
    end
    quiet();
    rst_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
